dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//  Load/store unit: the initiator side of the data-memory port (addr/wr_data/size/write/read -> rd_data).
//  Accepts one load or store at a time from the core's MEM stage via a valid/ready handshake.
//  Generates word-aligned addresses, byte strobes and lane-replicated write data.
//  Waits the memory's fixed read latency, then extracts and sign/zero-extends load data.
//  Flags misaligned or illegal accesses without touching memory.
// PARAMETERS
//  RD_LATENCY  1  cycles from o_data_read pulse to valid i_data_rd_data (legal 1..4)
// PORTS
//  i_clk             in   1   clock, all logic on rising edge
//  i_rst_n           in   1   synchronous active-low reset
//  i_req_valid       in   1   request present
//  o_req_ready       out  1   request accepted when valid&ready
//  i_req_we          in   1   1=store, 0=load
//  i_req_funct3      in   3   RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  i_req_addr        in   32  byte address
//  i_req_wdata       in   32  store data, right-justified
//  o_rsp_valid       out  1   one-cycle response pulse, no back-pressure
//  o_rsp_rdata       out  32  extended load data (0 for stores/errors)
//  o_rsp_err         out  1   misaligned or illegal funct3; qualified by o_rsp_valid
//  o_data_addr       out  32  {addr[31:2],2'b00}
//  o_data_wr_data    out  32  lane-replicated store data
//  o_data_size       out  4   byte strobes (writes); 4'b1111 on reads
//  o_data_write      out  1   one-cycle write pulse
//  o_data_read       out  1   one-cycle read pulse
//  i_data_rd_data    in   32  memory read word
// BEHAVIOUR
//  Reset: state IDLE; o_req_ready=1 after reset; all other outputs 0; latency counter 0.
//  FSM: IDLE -> ISSUE -> (load ok: RD_WAIT) -> RESP -> IDLE; store or error: ISSUE -> RESP.
//  IDLE: o_req_ready=1; on valid&ready (cycle T) register we/funct3/addr/wdata; go ISSUE.
//  ISSUE (T+1): registered memory outputs active for exactly this cycle.
//   Store ok: o_data_write=1; load ok: o_data_read=1, counter loads RD_LATENCY.
//   Error: no write/read pulse; the address/data/strobe outputs stay 0.
//  RD_WAIT: decrement counter; at 0, capture i_data_rd_data (sampled at T+1+RD_LATENCY).
//  RESP: o_rsp_valid=1 for one cycle; store/error at T+2, load at T+2+RD_LATENCY.
//  RESP cycle: o_req_ready=1 and a new request may be accepted (state -> ISSUE).
//  o_req_ready=0 in ISSUE and RD_WAIT.
//  Strobes: B = 4'b0001<<addr[1:0]; H = 4'b0011<<{addr[1],1'b0}; W = 4'b1111.
//  Wdata: B {4{wdata[7:0]}}; H {2{wdata[15:0]}}; W wdata.
//  Load extract: shift word right by 8*addr[1:0].
//   B/H sign-extend from bit 7/15; BU/HU zero-extend; W as-is.
//  Error conditions:
//   H/HU with addr[0]=1; W with addr[1:0]!=0.
//   funct3 in {011,110,111}; store with funct3 100/101.
//  Outputs not listed active in a state are driven 0; o_rsp_rdata holds 0 except in RESP.
//  Reset mid-operation (any state): next cycle IDLE and reset values; a pending read response
//   is dropped, no o_rsp_valid.
// TESTING
//  SB addr 0x103 wdata 0x000000A5 -> T+1: write=1, addr 0x100, size 4'b1000, wr_data 0xA5A5A5A5;
//   T+2: rsp_valid=1, err=0.
//  LB / LBU addr 0x103, mem word 0xA5000000, RD_LATENCY=1 -> read pulse T+1;
//   rsp T+3 rdata 0xFFFFFFA5 / 0x000000A5.
//  LH / LHU addr 0x102, mem 0x80017FFF -> rdata 0xFFFF8001 / 0x00008001.
//  RD_LATENCY=3: LW addr 0x200, mem 0xDEADBEEF -> read T+1; rsp T+5, rdata 0xDEADBEEF;
//   ready=0 T+1..T+4.
//  SW addr 0x102, and LH addr 0x101 -> no write/read pulse ever; rsp T+2, err=1, rdata 0.
//  i_req_valid held high: second request accepted in first's RESP cycle;
//   i_rst_n=0 during RD_WAIT -> no rsp_valid, ready=1 next cycle.

Source files
------------

// File: rtl/dmem_lsu_if.sv
// Bundle of the dmem_lsu request/response handshake and the data-memory port.
// Signal prefixes (i_/o_) are from the load/store unit's point of view.
interface dmem_lsu_if;
    // core request
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    // core response
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    // data-memory port
    logic [31:0] o_data_addr;
    logic [31:0] o_data_wr_data;
    logic [3:0]  o_data_size;
    logic        o_data_write;
    logic        o_data_read;
    logic [31:0] i_data_rd_data;

    // Requester / memory environment side
    modport master (
        output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_data_rd_data,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_data_addr, o_data_wr_data, o_data_size, o_data_write, o_data_read
    );

    // Load/store unit side
    modport slave (
        input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_data_rd_data,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_data_addr, o_data_wr_data, o_data_size, o_data_write, o_data_read
    );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding load/store unit driving a fixed-latency data memory.
// Aligns addresses, builds byte strobes and lane-replicated store data, waits the
// read latency, then extracts and extends load data. Misaligned or illegal
// accesses are answered with an error response and never reach memory.
module dmem_lsu #(
    parameter int RD_LATENCY = 1  // legal 1..4
) (
    input logic       i_clk,
    input logic       i_rst_n,
    dmem_lsu_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT,
        RESP
    } state_t;

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    state_t      state;
    state_t      state_next;

    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  lat_cnt;
    logic [31:0] load_word;

    logic        accept;
    logic        req_err;
    logic [3:0]  strobe;
    logic [31:0] lane_wdata;
    logic [31:0] load_shifted;
    logic [31:0] load_ext;

    // A request is taken whenever ready is high, which is IDLE or the RESP cycle.
    assign accept = bus.i_req_valid && (state == IDLE || state == RESP);

    // State register with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    // Request capture, read-latency counter and load-word capture.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            req_we     <= 1'b0;
            req_funct3 <= 3'b000;
            req_addr   <= 32'h0;
            req_wdata  <= 32'h0;
            lat_cnt    <= 3'd0;
            load_word  <= 32'h0;
        end else begin
            if (accept) begin
                req_we     <= bus.i_req_we;
                req_funct3 <= bus.i_req_funct3;
                req_addr   <= bus.i_req_addr;
                req_wdata  <= bus.i_req_wdata;
            end
            if (state == ISSUE && !req_err && !req_we) lat_cnt <= LAT;
            else if (state == RD_WAIT)                 lat_cnt <= lat_cnt - 3'd1;
            if (state == RD_WAIT && lat_cnt == 3'd1)   load_word <= bus.i_data_rd_data;
        end
    end

    // Decode the registered request: legality, byte strobes, lane-replicated data.
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        req_err    = 1'b0;
        strobe     = 4'b0000;
        lane_wdata = 32'h0;
        case (req_funct3)
            3'b000, 3'b100: begin  // B / BU
                strobe     = 4'b0001 << req_addr[1:0];
                lane_wdata = {4{req_wdata[7:0]}};
                req_err    = (req_funct3 == 3'b100) && req_we;
            end
            3'b001, 3'b101: begin  // H / HU
                strobe     = 4'b0011 << {req_addr[1], 1'b0};
                lane_wdata = {2{req_wdata[15:0]}};
                req_err    = req_addr[0] || ((req_funct3 == 3'b101) && req_we);
            end
            3'b010: begin          // W
                strobe     = 4'b1111;
                lane_wdata = req_wdata;
                req_err    = (req_addr[1:0] != 2'b00);
            end
            default: req_err = 1'b1;
        endcase
    end

    // Move the addressed byte/half to bit 0 and extend it by access type.
    always_comb begin
        load_shifted = load_word >> {req_addr[1:0], 3'b000};
        case (req_funct3)
            3'b000:  load_ext = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b100:  load_ext = {24'h0, load_shifted[7:0]};
            3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b101:  load_ext = {16'h0, load_shifted[15:0]};
            default: load_ext = load_shifted;
        endcase
    end

    // Next-state: loads detour through RD_WAIT, stores and errors go straight to RESP.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = (req_err || req_we) ? RESP : RD_WAIT;
            RD_WAIT: if (lat_cnt == 3'd1) state_next = RESP;
            RESP:    state_next = accept ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: memory port live only in ISSUE for legal accesses, response only in RESP.
    always_comb begin
        bus.o_req_ready    = (state == IDLE) || (state == RESP);
        bus.o_rsp_valid    = 1'b0;
        bus.o_rsp_rdata    = 32'h0;
        bus.o_rsp_err      = 1'b0;
        bus.o_data_addr    = 32'h0;
        bus.o_data_wr_data = 32'h0;
        bus.o_data_size    = 4'b0000;
        bus.o_data_write   = 1'b0;
        bus.o_data_read    = 1'b0;
        if (state == ISSUE && !req_err) begin
            bus.o_data_addr = {req_addr[31:2], 2'b00};
            if (req_we) begin
                bus.o_data_write   = 1'b1;
                bus.o_data_size    = strobe;
                bus.o_data_wr_data = lane_wdata;
            end else begin
                bus.o_data_read = 1'b1;
                bus.o_data_size = 4'b1111;
            end
        end
        if (state == RESP) begin
            bus.o_rsp_valid = 1'b1;
            bus.o_rsp_err   = req_err;
            bus.o_rsp_rdata = (!req_err && !req_we) ? load_ext : 32'h0;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: two instances (read latency 1 and 3) see identical request
// streams; each has its own memory model that returns the word only in the cycle
// the latency says it is valid.
module tb_dmem_lsu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] mem_word = 32'h0;

    dmem_lsu_if bus1 ();
    dmem_lsu_if bus3 ();

    assign bus1.i_req_valid  = req_valid;
    assign bus1.i_req_we     = req_we;
    assign bus1.i_req_funct3 = req_funct3;
    assign bus1.i_req_addr   = req_addr;
    assign bus1.i_req_wdata  = req_wdata;
    assign bus3.i_req_valid  = req_valid;
    assign bus3.i_req_we     = req_we;
    assign bus3.i_req_funct3 = req_funct3;
    assign bus3.i_req_addr   = req_addr;
    assign bus3.i_req_wdata  = req_wdata;

    // Read-pulse delay lines: bit k set means a read was issued k+1 cycles ago.
    logic [3:0] pipe1 = 4'h0;
    logic [3:0] pipe3 = 4'h0;
    always @(posedge clk) begin
        pipe1 <= {pipe1[2:0], bus1.o_data_read};
        pipe3 <= {pipe3[2:0], bus3.o_data_read};
    end
    assign bus1.i_data_rd_data = pipe1[0] ? mem_word : 32'h5A5A5A5A;
    assign bus3.i_data_rd_data = pipe3[2] ? mem_word : 32'h5A5A5A5A;

    dmem_lsu #(.RD_LATENCY(1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));
    dmem_lsu #(.RD_LATENCY(3)) dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus3));

    typedef struct packed {
        logic        ready;
        logic        write;
        logic        read;
        logic        rsp_valid;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wr;
        logic [31:0] rdata;
        logic [3:0]  size;
    } snap_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] daddr;
        logic [3:0]  size;
        logic [31:0] wr;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-DUT observations over one sequence (index 0: latency 1, index 1: latency 3)
    int          n_wr [2];
    int          n_rd [2];
    int          n_rsp [2];
    int          rsp_cyc [2];
    logic [31:0] r_data [2];
    logic        r_err [2];
    int          bus_bad [2];
    int          rdata_bad [2];
    logic [15:0] rdy_hist [2];
    int          log_cyc [2][4];
    logic [31:0] log_addr [2][4];
    logic [31:0] log_wr [2][4];
    logic [3:0]  log_size [2][4];

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic snap_t snap(input int d);
        snap_t s;
        if (d == 0) s = '{bus1.o_req_ready, bus1.o_data_write, bus1.o_data_read, bus1.o_rsp_valid,
                          bus1.o_rsp_err, bus1.o_data_addr, bus1.o_data_wr_data, bus1.o_rsp_rdata,
                          bus1.o_data_size};
        else        s = '{bus3.o_req_ready, bus3.o_data_write, bus3.o_data_read, bus3.o_rsp_valid,
                          bus3.o_rsp_err, bus3.o_data_addr, bus3.o_data_wr_data, bus3.o_rsp_rdata,
                          bus3.o_data_size};
        return s;
    endfunction

    task automatic clear_obs();
        for (int d = 0; d < 2; d++) begin
            n_wr[d] = 0; n_rd[d] = 0; n_rsp[d] = 0; rsp_cyc[d] = -1;
            r_data[d] = 32'h0; r_err[d] = 1'b0; bus_bad[d] = 0; rdata_bad[d] = 0;
            rdy_hist[d] = 16'h0;
            for (int k = 0; k < 4; k++) begin
                log_cyc[d][k] = -1; log_addr[d][k] = 32'h0; log_wr[d][k] = 32'h0; log_size[d][k] = 4'h0;
            end
        end
    endtask

    // Record both DUTs' outputs for cycle c (relative to the accept cycle).
    task automatic sample(input int c);
        snap_t s;
        int    p;
        for (int d = 0; d < 2; d++) begin
            s = snap(d);
            rdy_hist[d][c] = s.ready;
            if (s.write || s.read) begin
                p = n_wr[d] + n_rd[d];
                if (p < 4) begin
                    log_cyc[d][p] = c; log_addr[d][p] = s.addr; log_wr[d][p] = s.wr; log_size[d][p] = s.size;
                end
                if (s.write) n_wr[d]++;
                if (s.read)  n_rd[d]++;
            end else if (s.addr != 32'h0 || s.wr != 32'h0 || s.size != 4'h0) begin
                bus_bad[d]++;
            end
            if (s.rsp_valid) begin
                n_rsp[d]++; rsp_cyc[d] = c; r_data[d] = s.rdata; r_err[d] = s.err;
            end else if (s.rdata != 32'h0) begin
                rdata_bad[d]++;
            end
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] mem, input logic err,
                                input logic [31:0] rdata, input logic [31:0] daddr,
                                input logic [3:0] size, input logic [31:0] wr);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.mem = mem;
        v.err = err; v.rdata = rdata; v.daddr = daddr; v.size = size; v.wr = wr;
        return v;
    endfunction

    // Issue one request in cycle 0 and watch cycles 0..8.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr;
        req_wdata = v.wdata; mem_word = v.mem;
        clear_obs();
        sample(0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            sample(c);
        end
    endtask

    task automatic check_vec(input int i, input vec_t v);
        int          lat;
        int          exp_rsp;
        logic [15:0] exp_rdy;
        string       tag;
        for (int d = 0; d < 2; d++) begin
            lat     = (d == 0) ? 1 : 3;
            tag     = $sformatf("v%0d/L%0d", i, lat);
            exp_rsp = (v.err || v.we) ? 2 : 2 + lat;
            exp_rdy = 16'h0;
            for (int c = 0; c <= 8; c++) exp_rdy[c] = (c == 0) || (c >= exp_rsp);
            check({tag, " rsp_count"}, n_rsp[d], 1);
            check({tag, " rsp_cycle"}, rsp_cyc[d], exp_rsp);
            check({tag, " rdata"}, r_data[d], v.rdata);
            check({tag, " err"}, {31'h0, r_err[d]}, {31'h0, v.err});
            check({tag, " write_pulses"}, n_wr[d], (v.we && !v.err) ? 1 : 0);
            check({tag, " read_pulses"}, n_rd[d], (!v.we && !v.err) ? 1 : 0);
            if (!v.err) begin
                check({tag, " pulse_cycle"}, log_cyc[d][0], 1);
                check({tag, " data_addr"}, log_addr[d][0], v.daddr);
                check({tag, " data_size"}, {28'h0, log_size[d][0]}, {28'h0, v.size});
                check({tag, " wr_data"}, log_wr[d][0], v.wr);
            end
            check({tag, " idle_bus_zero"}, bus_bad[d], 0);
            check({tag, " rdata_zero_outside_resp"}, rdata_bad[d], 0);
            check({tag, " ready_history"}, {16'h0, rdy_hist[d]}, {16'h0, exp_rdy});
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        snap_t s;
        //            we  f3      addr          wdata         mem           err  rdata         daddr         size     wr
        vecs[0]  = mk(1, 3'b000, 32'h00000103, 32'h000000A5, 32'h0,        0, 32'h0,        32'h00000100, 4'b1000, 32'hA5A5A5A5);
        vecs[1]  = mk(0, 3'b000, 32'h00000103, 32'h0,        32'hA5000000, 0, 32'hFFFFFFA5, 32'h00000100, 4'b1111, 32'h0);
        vecs[2]  = mk(0, 3'b100, 32'h00000103, 32'h0,        32'hA5000000, 0, 32'h000000A5, 32'h00000100, 4'b1111, 32'h0);
        vecs[3]  = mk(0, 3'b001, 32'h00000102, 32'h0,        32'h80017FFF, 0, 32'hFFFF8001, 32'h00000100, 4'b1111, 32'h0);
        vecs[4]  = mk(0, 3'b101, 32'h00000102, 32'h0,        32'h80017FFF, 0, 32'h00008001, 32'h00000100, 4'b1111, 32'h0);
        vecs[5]  = mk(0, 3'b010, 32'h00000200, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 32'h00000200, 4'b1111, 32'h0);
        vecs[6]  = mk(1, 3'b010, 32'h00000102, 32'h12345678, 32'h0,        1, 32'h0,        32'h0,        4'b0000, 32'h0);
        vecs[7]  = mk(0, 3'b001, 32'h00000101, 32'h0,        32'h11223344, 1, 32'h0,        32'h0,        4'b0000, 32'h0);
        vecs[8]  = mk(1, 3'b001, 32'h00000106, 32'h1234ABCD, 32'h0,        0, 32'h0,        32'h00000104, 4'b1100, 32'hABCDABCD);
        vecs[9]  = mk(1, 3'b010, 32'h0000010C, 32'hCAFEF00D, 32'h0,        0, 32'h0,        32'h0000010C, 4'b1111, 32'hCAFEF00D);
        vecs[10] = mk(0, 3'b000, 32'h00000001, 32'h0,        32'h00007F00, 0, 32'h0000007F, 32'h00000000, 4'b1111, 32'h0);
        vecs[11] = mk(0, 3'b011, 32'h00000000, 32'h0,        32'h11111111, 1, 32'h0,        32'h0,        4'b0000, 32'h0);
        vecs[12] = mk(1, 3'b100, 32'h00000000, 32'h000000FF, 32'h0,        1, 32'h0,        32'h0,        4'b0000, 32'h0);
        vecs[13] = mk(0, 3'b010, 32'h00000203, 32'h0,        32'hDEADBEEF, 1, 32'h0,        32'h0,        4'b0000, 32'h0);
        vecs[14] = mk(0, 3'b001, 32'h00000000, 32'h0,        32'h0000FFFF, 0, 32'hFFFFFFFF, 32'h00000000, 4'b1111, 32'h0);
        vecs[15] = mk(1, 3'b000, 32'h00000101, 32'hFFFFFF3C, 32'h0,        0, 32'h0,        32'h00000100, 4'b0010, 32'h3C3C3C3C);
        vecs[16] = mk(0, 3'b110, 32'h00000000, 32'h0,        32'h11111111, 1, 32'h0,        32'h0,        4'b0000, 32'h0);
        vecs[17] = mk(1, 3'b101, 32'h00000000, 32'h0000BEEF, 32'h0,        1, 32'h0,        32'h0,        4'b0000, 32'h0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            s = snap(d);
            check($sformatf("reset/%0d ready", d), {31'h0, s.ready}, 32'h1);
            check($sformatf("reset/%0d write_read_rsp", d), {29'h0, s.write, s.read, s.rsp_valid}, 32'h0);
            check($sformatf("reset/%0d addr", d), s.addr, 32'h0);
            check($sformatf("reset/%0d wr_data", d), s.wr, 32'h0);
            check($sformatf("reset/%0d size_err", d), {27'h0, s.err, s.size}, 32'h0);
            check($sformatf("reset/%0d rdata", d), s.rdata, 32'h0);
        end

        // Table-driven single transactions
        for (int i = 0; i < 18; i++) begin
            run_vec(vecs[i]);
            check_vec(i, vecs[i]);
        end

        // Back-to-back: valid held high, second store taken in the first's RESP cycle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h00000100; req_wdata = 32'h00000011;
        clear_obs();
        sample(0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_funct3 = 3'b001; req_addr = 32'h00000102; req_wdata = 32'h00002222;
            end
            if (c == 3) req_valid = 1'b0;
            sample(c);
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("b2b/%0d writes", d), n_wr[d], 2);
            check($sformatf("b2b/%0d rsps", d), n_rsp[d], 2);
            check($sformatf("b2b/%0d last_rsp_cycle", d), rsp_cyc[d], 4);
            check($sformatf("b2b/%0d w0_cycle", d), log_cyc[d][0], 1);
            check($sformatf("b2b/%0d w0_data", d), log_wr[d][0], 32'h11111111);
            check($sformatf("b2b/%0d w0_size", d), {28'h0, log_size[d][0]}, 32'h1);
            check($sformatf("b2b/%0d w1_cycle", d), log_cyc[d][1], 3);
            check($sformatf("b2b/%0d w1_addr", d), log_addr[d][1], 32'h00000100);
            check($sformatf("b2b/%0d w1_data", d), log_wr[d][1], 32'h22222222);
            check($sformatf("b2b/%0d w1_size", d), {28'h0, log_size[d][1]}, 32'hC);
            check($sformatf("b2b/%0d ready_history", d), {16'h0, rdy_hist[d]}, 32'h000001F5);
        end

        // Reset while both instances wait for read data: the response is dropped
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h00000200; mem_word = 32'hDEADBEEF;
        clear_obs();
        sample(0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (c == 2) rst_n = 1'b0;
            if (c == 3) rst_n = 1'b1;
            sample(c);
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_mid/%0d reads", d), n_rd[d], 1);
            check($sformatf("rst_mid/%0d no_rsp", d), n_rsp[d], 0);
            check($sformatf("rst_mid/%0d ready_history", d), {16'h0, rdy_hist[d]}, 32'h000001F9);
            check($sformatf("rst_mid/%0d rdata_zero", d), rdata_bad[d], 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
